// File: rtl/ysyx_22041412_mdu_ctrl_pkg.sv
// Shared definitions for the RV64M multiply/divide controller:
// FSM state encodings, M-extension func3 codes, iteration counts
// and the final sign/width fix-up applied to a finished result.
package ysyx_22041412_mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] ITER_D = 7'd64;
    localparam logic [6:0] ITER_W = 7'd32;

    // {rs1 is signed, rs2 is signed} for each op
    function automatic logic [1:0] op_signed(input logic [2:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: op_signed = 2'b11;
            F3_MULHSU:                       op_signed = 2'b10;
            F3_MULHU, F3_DIVU, F3_REMU:      op_signed = 2'b00;
            default:                         op_signed = 2'b00;
        endcase
    endfunction

    function automatic logic [63:0] w_ext(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // mag holds either the unsigned 128-bit product or {remainder, quotient}
    // computed on absolute values; restore signs, select the half, W-extend.
    function automatic logic [63:0] fix_result(input logic [2:0] f3, input logic word,
                                               input logic neg_a, input logic neg_b,
                                               input logic [127:0] mag);
        logic [127:0] prod;
        logic [63:0]  quo;
        logic [63:0]  rem;
        logic [63:0]  res;
        prod = (neg_a ^ neg_b) ? -mag : mag;
        quo  = (neg_a ^ neg_b) ? -mag[63:0] : mag[63:0];
        rem  = neg_a ? -mag[127:64] : mag[127:64];
        if (!f3[2])
            res = (f3 == F3_MUL) ? prod[63:0] : prod[127:64];
        else
            res = f3[1] ? rem : quo;
        return word ? w_ext(res) : res;
    endfunction

endpackage

// File: rtl/ysyx_22041412_mdu_step.sv
// One iteration of the shared 128-bit working register:
//   multiply: shift-add, multiplier consumed from work[0], partial product in the top half
//   divide:   restoring step, remainder in the top half, quotient bits shifted in at work[0]
module ysyx_22041412_mdu_step (
    input  logic [127:0] work,
    input  logic [63:0]  operand,
    input  logic         is_div,
    output logic [127:0] work_next
);

    logic [64:0] sum;
    logic        fits;

    // Single combinational step, selected by operation class
    always_comb begin
        sum  = {1'b0, work[127:64]} + {1'b0, (work[0] ? operand : 64'd0)};
        // shifted remainder is work[127:63]; it is always below 2*operand
        fits = work[127:63] >= {1'b0, operand};
        if (!is_div)
            work_next = {sum, work[63:1]};
        else if (fits)
            work_next = {work[126:63] - operand, work[62:0], 1'b1};
        else
            work_next = {work[126:0], 1'b0};
    end

endmodule

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Iterative RV64M multiply/divide controller with valid/ready handshakes.
// Optional macro YSYX_22041412_MUL_FAST_EN: multiplies finish in one cycle
// with a combinational 128-bit product; division stays iterative.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// CALC  | one step per cycle, counter runs N..1
// DONE  | out_valid=1, result held until out_ready
module ysyx_22041412_mdu_ctrl
    import ysyx_22041412_mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  func3,
    input  logic        is_word,
    input  logic [63:0] scr1,
    input  logic [63:0] scr2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    mdu_state_e   state, state_next;
    logic [6:0]   cnt;
    logic [2:0]   op_f3;
    logic         op_word, op_neg_a, op_neg_b;
    logic [63:0]  op_b;
    logic [127:0] work, work_step, work_mag;

    logic [1:0]   sgn;
    logic         eff_word, neg_a, neg_b;
    logic         accept, div_zero, div_ovf, special, fast_mul;
    logic [63:0]  opa, opb, abs_a, abs_b, min_neg, special_res, accept_res;

    // Operand conditioning and special-case detection at accept time
    always_comb begin
        sgn      = op_signed(func3);
        eff_word = is_word & ((func3 == F3_MUL) | func3[2]);
        opa      = scr1;
        opb      = scr2;
        if (eff_word) begin
            opa = sgn[1] ? w_ext(scr1) : {32'd0, scr1[31:0]};
            opb = sgn[0] ? w_ext(scr2) : {32'd0, scr2[31:0]};
        end
        neg_a    = sgn[1] & opa[63];
        neg_b    = sgn[0] & opb[63];
        abs_a    = neg_a ? -opa : opa;
        abs_b    = neg_b ? -opb : opb;
        min_neg  = eff_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = func3[2] & (opb == 64'd0);
        div_ovf  = func3[2] & ~func3[0] & (opa == min_neg) & (&opb);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = func3[1] ? opa : {64{1'b1}};
        else
            special_res = func3[1] ? 64'd0 : opa;
        if (eff_word)
            special_res = w_ext(special_res);
    end

`ifdef YSYX_22041412_MUL_FAST_EN
    logic [127:0] fast_prod;
    assign fast_mul   = ~func3[2];
    assign fast_prod  = {64'd0, abs_a} * {64'd0, abs_b};
    assign accept_res = special ? special_res
                                : fix_result(func3, eff_word, neg_a, neg_b, fast_prod);
`else
    assign fast_mul   = 1'b0;
    assign accept_res = special_res;
`endif

    assign accept = in_valid & (state == MDU_IDLE) & ~flush;

    // A word multiply finishes with the product sitting 32 bits up
    assign work_mag = (~op_f3[2] & op_word) ? {32'd0, work_step[127:32]} : work_step;

    ysyx_22041412_mdu_step u_step (
        .work      (work),
        .operand   (op_b),
        .is_div    (op_f3[2]),
        .work_next (work_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= MDU_IDLE;
        else
            state <= state_next;
    end

    // Next state and handshake outputs; flush overrides every transition
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            MDU_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept)
                    state_next = (special | fast_mul) ? MDU_DONE : MDU_CALC;
            end
            MDU_CALC: begin
                if (cnt == 7'd1)
                    state_next = MDU_DONE;
            end
            MDU_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = MDU_IDLE;
            end
            default: state_next = MDU_IDLE;
        endcase
        if (flush)
            state_next = MDU_IDLE;
    end

    // Operand latch, iteration counter, working register and result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 7'd0;
            op_f3    <= 3'd0;
            op_word  <= 1'b0;
            op_neg_a <= 1'b0;
            op_neg_b <= 1'b0;
            op_b     <= 64'd0;
            work     <= 128'd0;
            result   <= 64'd0;
        end else if (accept) begin
            op_f3    <= func3;
            op_word  <= eff_word;
            op_neg_a <= neg_a;
            op_neg_b <= neg_b;
            cnt      <= eff_word ? ITER_W : ITER_D;
            if (func3[2]) begin
                op_b <= abs_b;
                work <= eff_word ? {64'd0, abs_a[31:0], 32'd0} : {64'd0, abs_a};
            end else begin
                op_b <= abs_a;
                work <= {64'd0, abs_b};
            end
            if (special | fast_mul)
                result <= accept_res;
        end else if (state == MDU_CALC && !flush) begin
            work <= work_step;
            cnt  <= cnt - 7'd1;
            if (cnt == 7'd1)
                result <= fix_result(op_f3, op_word, op_neg_a, op_neg_b, work_mag);
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Bench for the RV64M multiply/divide controller: directed vectors,
// flush / reset / backpressure sequences and randomized operations
// compared against an arithmetic reference model.
module tb_ysyx_22041412_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
    logic [2:0]  func3;
    logic [63:0] scr1, scr2, result;

    int checks   = 0;
    int failures = 0;

`ifdef YSYX_22041412_MUL_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int MUL_LAT_D = FAST ? 1 : 65;
    localparam int MUL_LAT_W = FAST ? 1 : 33;

    ysyx_22041412_mdu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .is_word   (is_word),
        .scr1      (scr1),
        .scr2      (scr2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result straight from the RV64M definitions
    function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa128, sb128, sp;
        logic [127:0]        ua128, ub128, up;
        logic signed [63:0]  sa64, sb64;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         ua32, ub32, r32;
        logic [63:0]         r;
        sa128 = {{64{a[63]}}, a};
        sb128 = {{64{b[63]}}, b};
        ua128 = {64'd0, a};
        ub128 = {64'd0, b};
        sa64  = a;
        sb64  = b;
        sa32  = a[31:0];
        sb32  = b[31:0];
        ua32  = a[31:0];
        ub32  = b[31:0];
        r     = 64'd0;
        r32   = 32'd0;
        if (w && (f3 == 3'b000 || f3[2])) begin
            case (f3)
                3'b000: r32 = ua32 * ub32;
                3'b100: begin
                    if (sb32 == 0) r32 = 32'hFFFF_FFFF;
                    else if (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) r32 = sa32;
                    else r32 = sa32 / sb32;
                end
                3'b101: begin
                    if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                    else r32 = ua32 / ub32;
                end
                3'b110: begin
                    if (sb32 == 0) r32 = sa32;
                    else if (sa32 == 32'sh8000_0000 && sb32 == -32'sd1) r32 = 32'd0;
                    else r32 = sa32 % sb32;
                end
                default: begin
                    if (ub32 == 0) r32 = ua32;
                    else r32 = ua32 % ub32;
                end
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (f3)
                3'b000: begin up = ua128 * ub128; r = up[63:0]; end
                3'b001: begin sp = sa128 * sb128; r = sp[127:64]; end
                3'b010: begin sp = sa128 * $signed(ub128); r = sp[127:64]; end
                3'b011: begin up = ua128 * ub128; r = up[127:64]; end
                3'b100: begin
                    if (sb64 == 0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && sb64 == -64'sd1) r = a;
                    else r = sa64 / sb64;
                end
                3'b101: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                3'b110: begin
                    if (sb64 == 0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && sb64 == -64'sd1) r = 64'd0;
                    else r = sa64 % sb64;
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    // Cycles from accept edge until out_valid is first seen
    function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic wd, bz, ovf;
        wd = w && (f3 == 3'b000 || f3[2]);
        if (!f3[2]) return FAST ? 1 : (wd ? 33 : 65);
        bz  = wd ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = !f3[0] && (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1));
        return (bz || ovf) ? 1 : (wd ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 9));
            4: return {32'($urandom), 32'h8000_0000};
            5: return {32'($urandom), 32'hFFFF_FFFF};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic do_op(input string name, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_r, input int exp_lat, input int hold);
        int k;
        int bad;
        @(negedge clk);
        chk({name, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        func3    = f3;
        is_word  = w;
        scr1     = a;
        scr2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        func3    = 3'($urandom);
        is_word  = 1'($urandom);
        scr1     = {32'($urandom), 32'($urandom)};
        scr2     = {32'($urandom), 32'($urandom)};
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({name, ":latency"}, 64'(k), 64'(exp_lat));
        chk({name, ":result"}, result, exp_r);
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (result !== exp_r || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            end
            chk({name, ":hold_stable"}, 64'(bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, ":ready_after_hs"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int k;
        logic [2:0]  rf3;
        logic        rw;
        logic [63:0] ra, rb;

        vecs[0]  = '{"mul_neg",     3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT_D, 5};
        vecs[1]  = '{"div_neg",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0};
        vecs[2]  = '{"rem_neg",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1};
        vecs[3]  = '{"mulhu",       3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, MUL_LAT_D, 0};
        vecs[4]  = '{"divu_zero",   3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2};
        vecs[5]  = '{"remu_zero",   3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0};
        vecs[6]  = '{"div_ovf",     3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0};
        vecs[7]  = '{"rem_ovf",     3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0};
        vecs[8]  = '{"mulw",        3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT_W, 0};
        vecs[9]  = '{"divuw",       3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0};
        vecs[10] = '{"divw_ovf",    3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0};
        vecs[11] = '{"remw_garbage",3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0};
        vecs[12] = '{"mulh_m1",     3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, MUL_LAT_D, 0};
        vecs[13] = '{"mulhsu_m1",   3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT_D, 0};
        vecs[14] = '{"mulhu_w_ign", 3'b011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, MUL_LAT_D, 0};

        rst_n = 1'b0; in_valid = 1'b0; func3 = 3'd0; is_word = 1'b0;
        scr1 = 64'd0; scr2 = 64'd0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", {result, 60'd0, in_ready, busy, out_valid, 1'b0}, {64'd0, 60'd0, 4'b1000});

        for (int i = 0; i < 15; i++)
            do_op(vecs[i].name, vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b,
                  vecs[i].r, vecs[i].lat, vecs[i].hold);

        // flush during a divide, then a fresh op two cycles later
        @(negedge clk);
        in_valid = 1'b1; func3 = 3'b100; is_word = 1'b0; scr1 = 64'd1000; scr2 = 64'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (out_valid) k++;
        chk("flush_idle_after", {62'd0, in_ready, busy}, 64'b10);
        chk("flush_no_valid", 64'(k), 64'd0);
        do_op("after_flush", 3'b100, 1'b0, 64'd1000, 64'd7, 64'd142, 65, 0);

        // in_valid together with flush in IDLE is ignored
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; func3 = 3'b000; scr1 = 64'd3; scr2 = 64'd4;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_blocks_accept", {62'd0, in_ready, busy}, 64'b10);

        // reset in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; func3 = 3'b101; is_word = 1'b0; scr1 = 64'd99; scr2 = 64'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("calc_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_calc", {result, 61'd0, in_ready, busy, out_valid}, {64'd0, 61'd0, 3'b100});
        repeat (70) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("rst_no_output", 64'(k), 64'd0);

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            ra  = pick();
            rb  = pick();
            do_op("random", rf3, rw, ra, rb, ref_mdu(rf3, rw, ra, rb),
                  ref_lat(rf3, rw, ra, rb), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
